// File: rtl/regfile_wr_demux_pkg.sv
// Shared constants and types for the register bank and its write-select demux.
// Build option: REGFILE_BYPASS_EN enables write-through forwarding on the read ports.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = reg_addr_t'(0);
  localparam reg_addr_t REG_SP   = reg_addr_t'(29);
  localparam word_t     SP_INIT  = 32'h0000_00E3;

endpackage

// File: rtl/regfile_wr_demux_if.sv
// Register-bank access bundle: one write port, two read ports and the write trace.
interface regfile_wr_demux_if;
  import regfile_pkg::*;

  logic                wr_en;
  reg_addr_t           wr_addr;
  word_t               wr_data;
  reg_addr_t           rd_addr_a;
  reg_addr_t           rd_addr_b;
  word_t               rd_data_a;
  word_t               rd_data_b;
  logic [NUM_REGS-1:0] wr_onehot;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wr_onehot
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wr_onehot
  );

endinterface

// File: rtl/regfile_wr_demux_wr_addr_decoder.sv
// Enabled index-to-one-hot decoder; bit 0 never asserts and out-of-range indices decode to nothing.
module wr_addr_decoder #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] dec
);

  always_comb begin
    dec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      dec[i] = en && (addr == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/regfile_wr_demux.sv
// 32x32 register bank with one-hot write demux, two combinational read ports, r0 tied to zero.
// Build option: REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_wr_demux
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  regfile_wr_demux_if.slave bus
);

  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] onehot_q;
  word_t               regs [NUM_REGS];

  wr_addr_decoder #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_wr_dec (
    .en   (bus.wr_en),
    .addr (bus.wr_addr),
    .dec  (dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      regs[REG_SP] <= SP_INIT;
      onehot_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (dec[i]) regs[i] <= bus.wr_data;
      end
      onehot_q <= dec;
    end
  end

  assign bus.wr_onehot = onehot_q;

  function automatic word_t read_port(input reg_addr_t ra);
    word_t val;
    val = (ra == REG_ZERO) ? '0 : regs[ra];
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write so decode sees it without a stall.
    if (bus.wr_en && (bus.wr_addr != REG_ZERO) && (ra == bus.wr_addr)) val = bus.wr_data;
`endif
    return val;
  endfunction

  assign bus.rd_data_a = read_port(bus.rd_addr_a);
  assign bus.rd_data_b = read_port(bus.rd_addr_b);

endmodule

// File: tb/tb_regfile_wr_demux.sv
// Randomized self-checking bench for regfile_wr_demux against an array-based register model.
module tb_regfile_wr_demux;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic run = 1'b0;

  regfile_wr_demux_if bus ();

  regfile_wr_demux dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always begin
    #5;
    if (run) clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[29] = 32'h0000_00E3;
  endtask

  function automatic logic [31:0] exp_rd(input int ra);
    if (ra == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && bus.wr_addr != 0 && int'(bus.wr_addr) == ra) return bus.wr_data;
`endif
    return model[ra];
  endfunction

  // One clock cycle: drive, check reads before the edge, then commit and check the trace.
  task automatic step(input logic we, input int wa, input logic [31:0] wd,
                      input int ra, input int rb);
    logic [31:0] exp_oh;
    @(negedge clk);
    bus.wr_en = we; bus.wr_addr = wa[4:0]; bus.wr_data = wd;
    bus.rd_addr_a = ra[4:0]; bus.rd_addr_b = rb[4:0];
    #1;
    check($sformatf("rd_a[%0d]", ra), bus.rd_data_a, exp_rd(ra));
    check($sformatf("rd_b[%0d]", rb), bus.rd_data_b, exp_rd(rb));
    exp_oh = (we && wa != 0) ? (32'h1 << wa) : 32'h0;
    if (we && wa != 0) model[wa] = wd;
    @(posedge clk);
    #1;
    check("wr_onehot", bus.wr_onehot, exp_oh);
  endtask

  task automatic sweep(input string tag);
    bus.wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr_a = i[4:0];
      bus.rd_addr_b = 5'(31 - i);
      #1;
      check($sformatf("%s_a[%0d]", tag, i), bus.rd_data_a, (i == 0) ? 32'h0 : model[i]);
      check($sformatf("%s_b[%0d]", tag, 31 - i), bus.rd_data_b, (i == 31) ? 32'h0 : model[31 - i]);
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    reset = 1'b1;
    model_reset();
    #2;
    check("reset_onehot", bus.wr_onehot, 32'h0);
    sweep("reset");
    run = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    step(1'b1, 5, 32'hDEAD_BEEF, 5, 0);
    step(1'b0, 0, 32'h0, 5, 5);
    check("r5_direct", bus.rd_data_a, 32'hDEAD_BEEF);

    step(1'b1, 0, 32'hFFFF_FFFF, 0, 5);
    sweep("r0write");

    step(1'b1, 7, 32'hAAAA_AAAA, 1, 2);
    step(1'b1, 7, 32'h1234_5678, 7, 7);
    step(1'b0, 0, 32'h0, 7, 7);
    check("r7_new", bus.rd_data_b, 32'h1234_5678);

    for (int i = 1; i < 32; i++)
      step(1'b1, i, 32'(i * 3), int'($urandom_range(0, 31)), i);
    sweep("walk");

    for (int n = 0; n < 400; n++) begin
      int wa;
      wa = (n % 7 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(1, 31));
      step(1'($urandom_range(0, 1)), wa, $urandom,
           ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)));
    end
    sweep("random");

    step(1'b1, 29, 32'h0000_0100, 29, 29);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd29; bus.wr_data = 32'h5555_5555;
    bus.rd_addr_a = 5'd29; bus.rd_addr_b = 5'd5;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("midrst_onehot", bus.wr_onehot, 32'h0);
    check("midrst_b5", bus.rd_data_b, 32'h0);
    bus.wr_en = 1'b0;
    #1;
    check("midrst_sp", bus.rd_data_a, 32'h0000_00E3);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    sweep("postrst");
    step(1'b1, 29, 32'hCAFE_0001, 29, 3);
    step(1'b0, 0, 32'h0, 29, 29);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
